// File: rtl/rd_tran_queue_n_if.sv
// Handshake and status bundle between the DMA arbiter and the read transaction queue.
// The slave modport is the queue's side; the master modport is the arbiter's side.
interface rd_tran_queue_n_if #(
  parameter int QUEUE_DEPTH         = 4,
  parameter int QUEUE_PTR_WIDTH     = 2,
  parameter int NUM_INT_BDS_WIDTH   = 5,
  parameter int NUM_PRI_LVLS        = 1,
  parameter int MAX_TRAN_SIZE_WIDTH = 23
) ();
  localparam int ENTRY_WIDTH = NUM_INT_BDS_WIDTH + MAX_TRAN_SIZE_WIDTH + NUM_PRI_LVLS + 108;

  logic                         doTrans;
  logic [ENTRY_WIDTH-1:0]       entry_DMAArbiter;
  logic                         popRdTranQueue;
  logic                         flushRdTranQueue;
  logic                         clrErr;
  logic                         reqInQueue;
  logic                         spaceRdTranQueue;
  logic [QUEUE_PTR_WIDTH:0]     freeSlots;
  logic [ENTRY_WIDTH-1:0]       headEntry;
  logic [NUM_PRI_LVLS-1:0]      headPriLvl;
  logic [NUM_INT_BDS_WIDTH-1:0] headIntDscrptrNum;
  logic                         pushErr;
  logic                         popErr;

  modport slave (
    input  doTrans, entry_DMAArbiter, popRdTranQueue, flushRdTranQueue, clrErr,
    output reqInQueue, spaceRdTranQueue, freeSlots, headEntry, headPriLvl,
           headIntDscrptrNum, pushErr, popErr
  );

  modport master (
    output doTrans, entry_DMAArbiter, popRdTranQueue, flushRdTranQueue, clrErr,
    input  reqInQueue, spaceRdTranQueue, freeSlots, headEntry, headPriLvl,
           headIntDscrptrNum, pushErr, popErr
  );
endinterface

// File: rtl/rd_tran_queue_n.sv
// Circular FIFO of pending read transactions with flush, sticky push/pop error flags
// and a zero-latency head view.
module rd_tran_queue_n #(
  parameter int QUEUE_DEPTH         = 4,
  parameter int QUEUE_PTR_WIDTH     = 2,
  parameter int NUM_INT_BDS_WIDTH   = 5,
  parameter int NUM_PRI_LVLS        = 1,
  parameter int MAX_TRAN_SIZE_WIDTH = 23
) (
  input  logic clock,
  input  logic resetn,
  rd_tran_queue_n_if.slave q
);
  localparam int ENTRY_WIDTH = NUM_INT_BDS_WIDTH + MAX_TRAN_SIZE_WIDTH + NUM_PRI_LVLS + 108;
  // priLvl sits just above nxtDscrptrNumAddr[31:0], extDscrptrNxt and chain.
  localparam int PRI_LSB = 34;

  localparam logic [QUEUE_PTR_WIDTH:0]   DEPTH_C  = (QUEUE_PTR_WIDTH+1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_PTR_WIDTH:0]   CNT_ZERO = {(QUEUE_PTR_WIDTH+1){1'b0}};
  localparam logic [QUEUE_PTR_WIDTH:0]   CNT_ONE  = {{QUEUE_PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [QUEUE_PTR_WIDTH-1:0] PTR_ZERO = {QUEUE_PTR_WIDTH{1'b0}};
  localparam logic [QUEUE_PTR_WIDTH-1:0] PTR_ONE  = {{(QUEUE_PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [QUEUE_PTR_WIDTH-1:0] PTR_LAST = QUEUE_PTR_WIDTH'(QUEUE_DEPTH - 1);

  logic [ENTRY_WIDTH-1:0]     mem_r [QUEUE_DEPTH];
  logic [QUEUE_PTR_WIDTH-1:0] wrPtr_r;
  logic [QUEUE_PTR_WIDTH-1:0] rdPtr_r;
  logic [QUEUE_PTR_WIDTH:0]   count_r;
  logic                       pushErr_r;
  logic                       popErr_r;

  logic full_s;
  logic pushAcc_s;
  logic popValid_s;
  logic pushOvf_s;
  logic popUnd_s;

  // Explicit wrap keeps the ordering correct even if the depth were not a power of two.
  function automatic logic [QUEUE_PTR_WIDTH-1:0] nextPtr(input logic [QUEUE_PTR_WIDTH-1:0] p);
    logic [QUEUE_PTR_WIDTH-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_ZERO;
    end else begin
      n = p + PTR_ONE;
    end
    return n;
  endfunction

  assign full_s = (count_r == DEPTH_C);

  // Qualify push/pop requests; flush suppresses every transfer and every error event.
  always_comb begin
    popValid_s = 1'b0;
    pushAcc_s  = 1'b0;
    pushOvf_s  = 1'b0;
    popUnd_s   = 1'b0;
    if (q.flushRdTranQueue) begin
      popValid_s = 1'b0;
      pushAcc_s  = 1'b0;
      pushOvf_s  = 1'b0;
      popUnd_s   = 1'b0;
    end else begin
      popValid_s = q.popRdTranQueue && (count_r != CNT_ZERO);
      pushAcc_s  = q.doTrans && (!full_s || popValid_s);
      pushOvf_s  = q.doTrans && full_s && !popValid_s;
      popUnd_s   = q.popRdTranQueue && (count_r == CNT_ZERO);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrPtr_r <= PTR_ZERO;
      rdPtr_r <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (q.flushRdTranQueue) begin
      wrPtr_r <= PTR_ZERO;
      rdPtr_r <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (pushAcc_s) begin
        wrPtr_r <= nextPtr(wrPtr_r);
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (popValid_s) begin
        rdPtr_r <= nextPtr(rdPtr_r);
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      case ({pushAcc_s, popValid_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; flush leaves contents alone since the head is qualified by reqInQueue.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_r[i] <= {ENTRY_WIDTH{1'b0}};
      end
    end else if (pushAcc_s) begin
      mem_r[wrPtr_r] <= q.entry_DMAArbiter;
    end else begin
      mem_r[wrPtr_r] <= mem_r[wrPtr_r];
    end
  end

  // Sticky error flags; a same-cycle error event beats clrErr.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pushErr_r <= 1'b0;
      popErr_r  <= 1'b0;
    end else begin
      if (pushOvf_s) begin
        pushErr_r <= 1'b1;
      end else if (q.clrErr) begin
        pushErr_r <= 1'b0;
      end else begin
        pushErr_r <= pushErr_r;
      end
      if (popUnd_s) begin
        popErr_r <= 1'b1;
      end else if (q.clrErr) begin
        popErr_r <= 1'b0;
      end else begin
        popErr_r <= popErr_r;
      end
    end
  end

  assign q.reqInQueue        = (count_r != CNT_ZERO);
  assign q.spaceRdTranQueue  = !full_s;
  assign q.freeSlots         = DEPTH_C - count_r;
  assign q.headEntry         = mem_r[rdPtr_r];
  assign q.headPriLvl        = q.headEntry[PRI_LSB +: NUM_PRI_LVLS];
  assign q.headIntDscrptrNum = q.headEntry[ENTRY_WIDTH-1 -: NUM_INT_BDS_WIDTH];
  assign q.pushErr           = pushErr_r;
  assign q.popErr            = popErr_r;

endmodule

// File: tb/tb_rd_tran_queue_n.sv
// Scoreboarded bench for rd_tran_queue_n: a depth-4 instance for directed scenarios and a
// depth-8 instance for pointer wrap-around.
module tb_rd_tran_queue_n;
  localparam int EW = 137;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  logic [EW-1:0] expQ4[$];
  logic [EW-1:0] expQ8[$];

  always #5 clock = ~clock;

  rd_tran_queue_n_if #(.QUEUE_DEPTH(4), .QUEUE_PTR_WIDTH(2)) m4 ();
  rd_tran_queue_n_if #(.QUEUE_DEPTH(8), .QUEUE_PTR_WIDTH(3)) m8 ();

  rd_tran_queue_n #(.QUEUE_DEPTH(4), .QUEUE_PTR_WIDTH(2)) dut4 (
    .clock(clock), .resetn(resetn), .q(m4));
  rd_tran_queue_n #(.QUEUE_DEPTH(8), .QUEUE_PTR_WIDTH(3)) dut8 (
    .clock(clock), .resetn(resetn), .q(m8));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkE(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // intDscrptrNum [136:132], srcAddr [97:66], priLvl [34], nxtDscrptrNumAddr [31:0]
  function automatic logic [EW-1:0] mkE(input logic [4:0] n, input logic p, input logic [31:0] a);
    logic [EW-1:0] e;
    e            = {EW{1'b0}};
    e[136:132]   = n;
    e[97:66]     = ~a;
    e[34]        = p;
    e[31:0]      = a;
    return e;
  endfunction

  task automatic op4(input logic push, input logic [EW-1:0] d, input logic pop,
                     input logic fl, input logic clr, input logic acc);
    m4.doTrans = push; m4.entry_DMAArbiter = d; m4.popRdTranQueue = pop;
    m4.flushRdTranQueue = fl; m4.clrErr = clr;
    if (acc) expQ4.push_back(d);
    @(posedge clock); #1;
    m4.doTrans = 1'b0; m4.entry_DMAArbiter = {EW{1'b0}}; m4.popRdTranQueue = 1'b0;
    m4.flushRdTranQueue = 1'b0; m4.clrErr = 1'b0;
  endtask

  task automatic op8(input logic push, input logic [EW-1:0] d, input logic pop, input logic acc);
    m8.doTrans = push; m8.entry_DMAArbiter = d; m8.popRdTranQueue = pop;
    if (acc) expQ8.push_back(d);
    @(posedge clock); #1;
    m8.doTrans = 1'b0; m8.entry_DMAArbiter = {EW{1'b0}}; m8.popRdTranQueue = 1'b0;
  endtask

  // Monitor: every pop of a non-empty queue must present the oldest expected entry.
  always @(negedge clock) begin
    if (resetn && m4.popRdTranQueue && !m4.flushRdTranQueue && m4.reqInQueue) begin
      if (expQ4.size() == 0) begin
        total++; bad++;
        $display("FAIL q4 pop: head %h presented but scoreboard empty", m4.headEntry);
      end else begin
        chkE("q4 head on pop", m4.headEntry, expQ4.pop_front());
      end
    end
    if (resetn && m8.popRdTranQueue && !m8.flushRdTranQueue && m8.reqInQueue) begin
      if (expQ8.size() == 0) begin
        total++; bad++;
        $display("FAIL q8 pop: head %h presented but scoreboard empty", m8.headEntry);
      end else begin
        chkE("q8 head on pop", m8.headEntry, expQ8.pop_front());
      end
    end
  end

  initial begin
    logic [EW-1:0] A, B, C, D, E, F, G, H, I, J, K, L, M, N, d;
    logic pp, acc;
    int cnt8;
    A = mkE(5'h11, 1'b1, 32'hA000_0001); B = mkE(5'h02, 1'b0, 32'hB000_0002);
    C = mkE(5'h03, 1'b1, 32'hC000_0003); D = mkE(5'h04, 1'b0, 32'hD000_0004);
    E = mkE(5'h05, 1'b1, 32'hE000_0005); F = mkE(5'h06, 1'b0, 32'hF000_0006);
    G = mkE(5'h07, 1'b1, 32'h1234_5678); H = mkE(5'h08, 1'b0, 32'h0000_0008);
    I = mkE(5'h09, 1'b1, 32'h0000_0009); J = mkE(5'h0A, 1'b0, 32'h0000_000A);
    K = mkE(5'h0B, 1'b1, 32'h0000_000B); L = mkE(5'h0C, 1'b0, 32'h0000_000C);
    M = mkE(5'h0D, 1'b1, 32'h0000_000D); N = mkE(5'h0E, 1'b0, 32'h0000_000E);

    m4.doTrans = 1'b0; m4.entry_DMAArbiter = {EW{1'b0}}; m4.popRdTranQueue = 1'b0;
    m4.flushRdTranQueue = 1'b0; m4.clrErr = 1'b0;
    m8.doTrans = 1'b0; m8.entry_DMAArbiter = {EW{1'b0}}; m8.popRdTranQueue = 1'b0;
    m8.flushRdTranQueue = 1'b0; m8.clrErr = 1'b0;

    // Reset values
    #2 resetn = 1'b0;
    #1;
    chk("rst reqInQueue", int'(m4.reqInQueue), 0);
    chk("rst space", int'(m4.spaceRdTranQueue), 1);
    chk("rst freeSlots", int'(m4.freeSlots), 4);
    chkE("rst headEntry", m4.headEntry, {EW{1'b0}});
    chk("rst pushErr", int'(m4.pushErr), 0);
    chk("rst popErr", int'(m4.popErr), 0);
    chk("rst8 freeSlots", int'(m8.freeSlots), 8);
    chkE("rst8 headEntry", m8.headEntry, {EW{1'b0}});
    @(posedge clock); #1;
    resetn = 1'b1;

    // Fill and order
    op4(1'b1, A, 1'b0, 1'b0, 1'b0, 1'b1);
    chkE("first push head", m4.headEntry, A);
    chk("first push reqInQueue", int'(m4.reqInQueue), 1);
    chk("head intDscrptrNum", int'(m4.headIntDscrptrNum), 17);
    chk("head priLvl", int'(m4.headPriLvl), 1);
    op4(1'b1, B, 1'b0, 1'b0, 1'b0, 1'b1);
    op4(1'b1, C, 1'b0, 1'b0, 1'b0, 1'b1);
    op4(1'b1, D, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full freeSlots", int'(m4.freeSlots), 0);
    chk("full space", int'(m4.spaceRdTranQueue), 0);
    chk("full reqInQueue", int'(m4.reqInQueue), 1);

    // Push and pop together while full
    op4(1'b1, E, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("push+pop freeSlots", int'(m4.freeSlots), 0);
    chkE("push+pop head", m4.headEntry, B);

    // Overflow drops the entry
    op4(1'b1, F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overflow pushErr", int'(m4.pushErr), 1);
    chk("overflow popErr", int'(m4.popErr), 0);
    chk("overflow freeSlots", int'(m4.freeSlots), 0);
    chkE("overflow head", m4.headEntry, B);

    repeat (4) op4(1'b0, {EW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drained reqInQueue", int'(m4.reqInQueue), 0);
    chk("drained freeSlots", int'(m4.freeSlots), 4);
    chk("drained space", int'(m4.spaceRdTranQueue), 1);
    chk("pushErr sticky", int'(m4.pushErr), 1);

    // Underflow with a same-cycle push that still lands
    op4(1'b1, G, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("underflow popErr", int'(m4.popErr), 1);
    chk("underflow push reqInQueue", int'(m4.reqInQueue), 1);
    chkE("underflow push head", m4.headEntry, G);
    op4(1'b0, {EW{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clrErr pushErr", int'(m4.pushErr), 0);
    chk("clrErr popErr", int'(m4.popErr), 0);
    op4(1'b0, {EW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);
    op4(1'b0, {EW{1'b0}}, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("error beats clrErr", int'(m4.popErr), 1);
    op4(1'b0, {EW{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clrErr popErr again", int'(m4.popErr), 0);

    // Flush with a simultaneous push
    op4(1'b1, H, 1'b0, 1'b0, 1'b0, 1'b1);
    op4(1'b1, I, 1'b0, 1'b0, 1'b0, 1'b1);
    op4(1'b1, J, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre-flush freeSlots", int'(m4.freeSlots), 1);
    op4(1'b1, K, 1'b0, 1'b1, 1'b0, 1'b0);
    expQ4.delete();
    chk("flush freeSlots", int'(m4.freeSlots), 4);
    chk("flush reqInQueue", int'(m4.reqInQueue), 0);
    chk("flush pushErr", int'(m4.pushErr), 0);
    chk("flush popErr", int'(m4.popErr), 0);
    op4(1'b1, L, 1'b0, 1'b0, 1'b0, 1'b1);
    chkE("post-flush head", m4.headEntry, L);
    op4(1'b0, {EW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset between clock edges
    op4(1'b0, {EW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);
    op4(1'b1, M, 1'b0, 1'b0, 1'b0, 1'b1);
    op4(1'b1, N, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre-reset popErr", int'(m4.popErr), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async rst reqInQueue", int'(m4.reqInQueue), 0);
    chk("async rst space", int'(m4.spaceRdTranQueue), 1);
    chk("async rst freeSlots", int'(m4.freeSlots), 4);
    chkE("async rst head", m4.headEntry, {EW{1'b0}});
    chk("async rst popErr", int'(m4.popErr), 0);
    expQ4.delete();
    expQ8.delete();
    @(posedge clock); #1;
    resetn = 1'b1;

    // Depth-8 wrap-around against a reference FIFO
    cnt8 = 0;
    for (int i = 0; i < 20; i++) begin
      d   = EW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      pp  = ((i % 3) == 2);
      acc = (cnt8 < 8) || (pp && (cnt8 > 0));
      op8(1'b1, d, pp, acc);
      if (acc && !(pp && (cnt8 > 0))) cnt8++;
      else if (!acc && pp && (cnt8 > 0)) cnt8--;
      chk("q8 freeSlots", int'(m8.freeSlots), 8 - cnt8);
      chk("q8 count bound", int'(m8.freeSlots <= 4'd8), 1);
    end
    while (cnt8 > 0) begin
      op8(1'b0, {EW{1'b0}}, 1'b1, 1'b0);
      cnt8--;
    end
    chk("q8 drained reqInQueue", int'(m8.reqInQueue), 0);
    chk("q8 scoreboard consumed", expQ8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
